// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // Control word the ID/EX mux selects when a bubble is inserted
  localparam logic [6:0] CTRL_NOP = 7'b0;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_bubble;
  } strobe_t;

  localparam strobe_t STB_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  localparam strobe_t STB_FREEZE = '{id_ex_stall: 1'b1, default: 1'b0};
  localparam strobe_t STB_BUBBLE = '{id_ex_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit signal bundle: ID/EX observations in, pipeline strobes and counters out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_uses_rs2_i;
  logic             ex_mem_read_i;
  logic [4:0]       ex_rd_i;
  logic             branch_taken_i;
  logic             dmem_busy_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_stall_o;
  logic             id_ex_bubble_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, dmem_busy_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_stall_o,
           id_ex_bubble_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_uses_rs2_i, ex_mem_read_i, ex_rd_i,
           branch_taken_i, dmem_busy_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_stall_o,
           id_ex_bubble_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= '0;
    else if (inc && ~&q) q <= q + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, dmem freeze, branch flush, timeout error.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_STALLS = 1,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 16
) (
  input logic               clk_i,
  input logic               rst_n_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int LCW = (LOAD_STALLS > 1) ? $clog2(LOAD_STALLS + 1) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  state_e         state, state_nxt;
  logic [LCW-1:0] lu_cnt, lu_cnt_nxt;
  logic [TCW-1:0] to_cnt;
  logic           lu, busy, timeout;
  strobe_t        stb;

  assign busy    = hz.dmem_busy_i;
  assign timeout = busy && (to_cnt == TCW'(TIMEOUT - 1));
  assign lu      = hz.ex_mem_read_i && (hz.ex_rd_i != REG_ZERO) &&
                   ((hz.ex_rd_i == hz.id_rs1_i) ||
                    (hz.id_uses_rs2_i && (hz.ex_rd_i == hz.id_rs2_i)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= RUN;
      lu_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      if (!busy)        to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + 1'b1;
    end
  end

  // Priority inside each state: freeze > load-use bubble > branch flush
  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    stb        = STB_RUN;
    case (state)
      RUN: begin
        if (busy) stb = STB_FREEZE;
        else if (lu) begin
          stb = STB_BUBBLE;
          if (LOAD_STALLS > 1) begin
            state_nxt  = LU_STALL;
            lu_cnt_nxt = LCW'(LOAD_STALLS - 1);
          end
        end else if (hz.branch_taken_i) stb.if_id_flush = 1'b1;
      end
      LU_STALL: begin
        if (busy) stb = STB_FREEZE;
        else begin
          stb        = STB_BUBBLE;
          lu_cnt_nxt = lu_cnt - LCW'(1);
          if (lu_cnt == LCW'(1)) state_nxt = RUN;
        end
      end
      ERROR:   stb = STB_FREEZE;
      default: state_nxt = RUN;
    endcase
    if (timeout) state_nxt = ERROR;
  end

  assign hz.pc_write_o     = stb.pc_write;
  assign hz.if_id_write_o  = stb.if_id_write;
  assign hz.if_id_flush_o  = stb.if_id_flush;
  assign hz.id_ex_stall_o  = stb.id_ex_stall;
  assign hz.id_ex_bubble_o = stb.id_ex_bubble;
  assign hz.err_o          = (state == ERROR);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (~stb.pc_write),
    .q     (hz.stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (stb.if_id_flush),
    .q     (hz.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a (1 load stall, timeout 8, 3-bit counters), dut_b (3 load stalls).
module tb_pipe_hazard_ctrl;

  localparam int CWA = 3;
  localparam int CWB = 16;

  // Strobe packing used in expectations: {pc_write, if_id_write, flush, stall, bubble}
  localparam logic [4:0] S_RUN = 5'b11000;
  localparam logic [4:0] S_FLS = 5'b11100;
  localparam logic [4:0] S_FRZ = 5'b00010;
  localparam logic [4:0] S_BUB = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic       u2, mr, br, busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CWA)) a_if ();
  pipe_hazard_ctrl_if #(.CNT_W(CWB)) b_if ();

  assign a_if.id_rs1_i = rs1;        assign b_if.id_rs1_i = rs1;
  assign a_if.id_rs2_i = rs2;        assign b_if.id_rs2_i = rs2;
  assign a_if.id_uses_rs2_i = u2;    assign b_if.id_uses_rs2_i = u2;
  assign a_if.ex_mem_read_i = mr;    assign b_if.ex_mem_read_i = mr;
  assign a_if.ex_rd_i = rd;          assign b_if.ex_rd_i = rd;
  assign a_if.branch_taken_i = br;   assign b_if.branch_taken_i = br;
  assign a_if.dmem_busy_i = busy;    assign b_if.dmem_busy_i = busy;

  pipe_hazard_ctrl #(.LOAD_STALLS(1), .TIMEOUT(8), .CNT_W(CWA)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .hz(a_if.slave));
  pipe_hazard_ctrl #(.LOAD_STALLS(3), .TIMEOUT(256), .CNT_W(CWB)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .hz(b_if.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u2, mr;
    logic [4:0] rd;
    logic       br, busy;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [4:0] strb_a();
    return {a_if.pc_write_o, a_if.if_id_write_o, a_if.if_id_flush_o,
            a_if.id_ex_stall_o, a_if.id_ex_bubble_o};
  endfunction

  function automatic logic [4:0] strb_b();
    return {b_if.pc_write_o, b_if.if_id_write_o, b_if.if_id_flush_o,
            b_if.id_ex_stall_o, b_if.id_ex_bubble_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u,
                       input logic m, input logic [4:0] d, input logic b, input logic bz);
    rs1 = r1; rs2 = r2; u2 = u; mr = m; rd = d; br = b; busy = bz;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic lu_rs1();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, S_RUN};
    tbl[1]  = '{5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, S_BUB};
    tbl[2]  = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, S_RUN};
    tbl[3]  = '{5'd3,  5'd7, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, S_BUB};
    tbl[4]  = '{5'd3,  5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, S_RUN};
    tbl[5]  = '{5'd5,  5'd0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, S_RUN};
    tbl[6]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, S_FLS};
    tbl[7]  = '{5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, S_BUB};
    tbl[8]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, S_FRZ};
    tbl[9]  = '{5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, S_FRZ};
    tbl[10] = '{5'd5,  5'd6, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, S_RUN};
    tbl[11] = '{5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, S_BUB};

    // 1: reset with random inputs, then idle strobes
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #2;
      chk("rst_err_a", a_if.err_o, 0);
      chk("rst_stall_cnt_a", a_if.stall_cnt_o, 0);
      chk("rst_flush_cnt_a", a_if.flush_cnt_o, 0);
      chk("rst_stall_cnt_b", b_if.stall_cnt_o, 0);
    end
    do_reset();
    chk("idle_strb_a", strb_a(), S_RUN);
    chk("idle_strb_b", strb_b(), S_RUN);
    chk("idle_err_b", b_if.err_o, 0);

    // 2: single-bubble load-use, and rd=x0 never stalls
    lu_rs1(); #1;
    chk("lu1_strb", strb_a(), S_BUB);
    tick();
    chk("lu1_stall_cnt", a_if.stall_cnt_o, 1);
    idle(); #1;
    chk("lu1_after", strb_a(), S_RUN);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_x0_strb", strb_a(), S_RUN);
    tick();
    chk("lu_x0_stall_cnt", a_if.stall_cnt_o, 1);

    // Table of single-cycle decodes on dut_a
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u2, tbl[i].mr, tbl[i].rd, tbl[i].br, tbl[i].busy);
      #1;
      chk($sformatf("vec%0d", i), strb_a(), tbl[i].exp);
      tick();
    end
    chk("tbl_stall_cnt", a_if.stall_cnt_o, 6);
    chk("tbl_flush_cnt", a_if.flush_cnt_o, 1);
    // 3-bit counter reaches 7 and sticks there
    lu_rs1(); tick();
    chk("sat_reach", a_if.stall_cnt_o, 7);
    repeat (3) tick();
    chk("sat_hold", a_if.stall_cnt_o, 7);

    // 3: three bubbles via rs2, none when rs2 is unused
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      else idle();
      #1;
      chk($sformatf("lu3_c%0d", i), strb_b(), (i < 3) ? S_BUB : S_RUN);
      tick();
    end
    chk("lu3_stall_cnt", b_if.stall_cnt_o, 3);
    drive(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0); #1;
    chk("lu3_nouse", strb_b(), S_RUN);
    tick();
    // Branch during the stall is ignored
    for (int i = 0; i < 4; i++) begin
      if (i == 0) lu_rs1();
      else if (i == 1) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      else idle();
      #1;
      chk($sformatf("lu3_br_c%0d", i), strb_b(), (i < 3) ? S_BUB : S_RUN);
      tick();
    end
    chk("lu3_br_stall_cnt", b_if.stall_cnt_o, 6);
    chk("lu3_br_flush_cnt", b_if.flush_cnt_o, 0);

    // 4: dmem busy for 4 cycles in the middle of a 3-bubble stall
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) lu_rs1();
      else if (i >= 2 && i <= 5) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      else idle();
      #1;
      chk($sformatf("frz_c%0d", i), strb_b(),
          (i >= 2 && i <= 5) ? S_FRZ : ((i == 7) ? S_RUN : S_BUB));
      tick();
    end
    chk("frz_stall_cnt", b_if.stall_cnt_o, 7);

    // 5: branch flush alone, and suppressed by a load-use
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); #1;
    chk("br_strb", strb_a(), S_FLS);
    tick();
    chk("br_flush_cnt", a_if.flush_cnt_o, 1);
    idle(); #1;
    chk("br_after", strb_a(), S_RUN);
    tick();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    chk("br_lu_strb", strb_a(), S_BUB);
    tick();
    chk("br_lu_flush_cnt", a_if.flush_cnt_o, 1);

    // 6: timeout counter clears on a gap; 8 busy cycles latch the error
    do_reset();
    busy = 1'b1; repeat (7) tick();
    busy = 1'b0; tick();
    busy = 1'b1; repeat (7) tick();
    chk("to_gap_err", a_if.err_o, 0);
    busy = 1'b0; tick();
    busy = 1'b1; repeat (7) tick();
    chk("to_7_err", a_if.err_o, 0);
    tick();
    busy = 1'b0; tick();
    chk("to_err_set", a_if.err_o, 1);
    #1;
    chk("to_err_strb", strb_a(), S_FRZ);
    repeat (3) tick();
    chk("to_err_sticky", a_if.err_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("to_err_rst", a_if.err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("to_post_rst_strb", strb_a(), S_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
